fft_bin_packer: RTL
===================

# fft_bin_packer

Downstream consumer of the four-lane polyphase FFT stage. Each input beat carries the complex outputs for bins k, k+N/4, k+N/2 and k+3N/4 on lanes 0..3 (N/4 = 16384). The block keeps only a configured k-window and lane subset, and buffers the selected words. It serializes each FFT frame into one 64-bit AXI-Stream packet: a header word, then the data words. The upstream stage has no backpressure, so frames that cannot fit in the buffer are dropped whole and counted.

## Interface
- FIFO_DEPTH, 1024: data FIFO entries (power of 2); each entry holds one input beat (4 lanes).
- HDR_DEPTH, 4: header FIFO entries (power of 2).

Ports:
- clk  in  1  single clock domain.
- resetn  in  1  reset; asynchronous, active-low.
- s_data_0 .. s_data_3  in  64 each  lane j = bin k + j·16384; [63:32] imag, [31:0] real.
- s_k  in  14  bin index within quarter.
- s_timestamp  in  32  frame timestamp; constant across a frame.
- s_valid  in  1  beat strobe; no ready.
- s_last  in  1  last beat of frame (k = 16383).
- cfg_k_lo, cfg_k_hi  in  14 each  inclusive k-window.
- cfg_lane_mask  in  4  lanes to emit.
- m_axis_tdata  out  64  packet word.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  last word of packet.
- frame_cnt  out  16  frames seen, including dropped frames; wraps.
- drop_cnt  out  16  frames dropped; saturates at 0xFFFF.
- overflow  out  1  sticky; set on first drop, cleared only by reset.

## Operation
- **Frame start.** The first s_valid beat after reset, or after an s_last beat.
  - Sample cfg_k_lo, cfg_k_hi, cfg_lane_mask and s_timestamp on this beat.
  - Config changes mid-frame are ignored.
- **Window length.** L = k_hi − k_lo + 1.
- **Null frame.** If k_lo > k_hi or mask == 0: frame_cnt increments; no packet is produced and no drop is counted.
- **Admission.** A frame is admitted only if all of the following hold at frame start:
  - s_k == 0;
  - data FIFO free entries ≥ L;
  - header FIFO is not full.
  - Otherwise the frame is dropped: drop_cnt +1, overflow ← 1, and no writes occur for the whole frame.
- **Header write.** On admission, write {s_timestamp, frame_cnt value before increment, 8'hA5, 4'b0, mask} to the header FIFO. frame_cnt increments at frame start.
- **Data writes.** For an admitted frame, each beat with k_lo ≤ s_k ≤ k_hi writes {last_flag, s_data_3..0} to the data FIFO. last_flag = (s_k == k_hi).
  - Because admission reserved L entries, the data FIFO cannot overflow.
- **Serializer FSM.**
  - IDLE: header FIFO non-empty → HDR.
  - HDR: present the header word. On handshake, pop it, set the lane pointer to the lowest set mask bit, and go to DATA.
  - DATA: present s_data_<lane> of the head entry. On handshake, advance to the next set bit. After the highest set bit, pop the entry.
  - m_axis_tlast = 1 on the highest lane of an entry with last_flag set. On that handshake, return to IDLE.
- **AXI-Stream rules.** Standard: tdata, tvalid and tlast stay stable while tvalid && !tready; tvalid never drops without a handshake.
- **Packet length.** 1 + L·popcount(mask) words.

## Timing
- **Reset.** Asynchronous assert; all outputs 0, both FIFOs empty, FSM in IDLE, frame tracking reset. A packet in flight at reset is truncated with no tlast.
- **Input latency.** An input beat is registered once, then written to the FIFO. Its entry is eligible at the FIFO head no earlier than cycle n+2 after the beat in cycle n.
- **Header latency.** With the FSM idle and tready held high, header tvalid rises exactly 2 cycles after the frame-start beat.
- **Throughput.** One output word per cycle while tready = 1. Sustained operation requires L·popcount(mask) + 1 ≤ 16384 words per frame; excess shows up as later drops, never as corruption.
- **Single-cycle events.** Frame start, header write, the data write for k_lo = 0 and frame_cnt increment may all fall in the same cycle; all take effect.
- **Drop counter.** drop_cnt and overflow update in the cycle after the rejecting frame-start beat.

## Test plan
- **Basic window.** k_lo=5, k_hi=7, mask=4'b0101, tready=1, one full frame with timestamp 0x12345678.
  - Expect 7 words: header 0x12345678_0000_A5_05, then lanes 0,2 for k=5,6,7.
  - tlast on the lane-2 word for k=7; header tvalid exactly 2 cycles after the k=0 beat.
- **Backpressure.** Same frame with tready toggled pseudo-randomly.
  - Identical word sequence, stable data while stalled, no drops.
- **Overflow.** FIFO_DEPTH=16, window 0..15, tready=0 over two frames.
  - Frame 0 admitted. Frame 1 dropped: drop_cnt=1, overflow=1, frame_cnt=2.
  - After tready=1, only the frame 0 packet (65 words, mask=4'hF) appears.
- **Null and boundary windows.**
  - k_lo=10, k_hi=3: no packet; frame_cnt increments.
  - k_lo=k_hi=16383, mask=4'b1000: 2-word packet, tlast on the data word.
- **Mid-frame starts.**
  - Assert resetn low during packet output: outputs 0 immediately.
  - Release reset mid-frame (first beat s_k=900): that frame is dropped, drop_cnt=1; the next frame packs normally.
- **Config change mid-frame.** Change cfg_lane_mask mid-frame.
  - The current packet uses the old mask; the next header shows the new mask.

Source files
------------

// File: rtl/fft_bin_packer.sv
// Packs a k-window and lane subset of four-lane FFT beats into one 64-bit
// AXI-Stream packet per frame: a header word followed by the selected lane words.
module fft_bin_packer #(
    parameter int FIFO_DEPTH = 1024,
    parameter int HDR_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] s_data_0,
    input  logic [63:0] s_data_1,
    input  logic [63:0] s_data_2,
    input  logic [63:0] s_data_3,
    input  logic [13:0] s_k,
    input  logic [31:0] s_timestamp,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic [13:0] cfg_k_lo,
    input  logic [13:0] cfg_k_hi,
    input  logic [3:0]  cfg_lane_mask,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic        overflow
);

    localparam int DAW = $clog2(FIFO_DEPTH);
    localparam int HAW = $clog2(HDR_DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_DATA = 2'd2} ser_state_t;

    // Frame tracking and input register stage
    logic         mid_frame;
    logic         f_active;
    logic [13:0]  f_k_lo;
    logic [13:0]  f_k_hi;
    logic         r_dwr;
    logic         r_hwr;
    logic [256:0] r_dword;
    logic [63:0]  r_hword;

    // FIFO storage
    logic [256:0]   d_mem [FIFO_DEPTH];
    logic [63:0]    h_mem [HDR_DEPTH];
    logic [DAW-1:0] d_wp, d_rp;
    logic [HAW-1:0] h_wp, h_rp;
    logic [DAW:0]   d_count;
    logic [HAW:0]   h_count;
    logic           d_empty, h_empty;
    logic           d_pop, h_pop;
    logic [256:0]   d_head;
    logic [63:0]    h_head;

    // Serializer
    ser_state_t state, state_d;
    logic [1:0] lane, lane_d;
    logic [3:0] p_mask, p_mask_d;

    logic        frame_start, win_null, admit, cur_active, in_window, dwr, hwr;
    logic [13:0] cur_lo, cur_hi;
    logic [14:0] win_len;
    logic [31:0] d_free, h_used;

    function automatic logic [1:0] low_lane(input logic [3:0] m);
        low_lane = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) low_lane = 2'(i);
    endfunction

    function automatic logic [1:0] high_lane(input logic [3:0] m);
        high_lane = 2'd0;
        for (int i = 0; i < 4; i++)
            if (m[i]) high_lane = 2'(i);
    endfunction

    function automatic logic [1:0] next_lane(input logic [3:0] m, input logic [1:0] cur);
        next_lane = cur;
        for (int i = 3; i >= 0; i--)
            if (m[i] && (2'(i) > cur)) next_lane = 2'(i);
    endfunction

    // Admission counts the word still sitting in the input register so a
    // reservation never overlaps the previous frame's final write.
    always_comb begin
        frame_start = s_valid && !mid_frame;
        win_null    = (cfg_k_lo > cfg_k_hi) || (cfg_lane_mask == 4'd0);
        win_len     = {1'b0, cfg_k_hi} - {1'b0, cfg_k_lo} + 15'd1;
        d_free      = 32'(FIFO_DEPTH) - 32'(d_count) - 32'(r_dwr);
        h_used      = 32'(h_count) + 32'(r_hwr);
        admit       = !win_null && (s_k == 14'd0) && (d_free >= 32'(win_len))
                      && (h_used < 32'(HDR_DEPTH));
        cur_active  = frame_start ? admit    : f_active;
        cur_lo      = frame_start ? cfg_k_lo : f_k_lo;
        cur_hi      = frame_start ? cfg_k_hi : f_k_hi;
        in_window   = (s_k >= cur_lo) && (s_k <= cur_hi);
        dwr         = s_valid && cur_active && in_window;
        hwr         = frame_start && admit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mid_frame <= 1'b0;
            f_active  <= 1'b0;
            f_k_lo    <= '0;
            f_k_hi    <= '0;
            r_dwr     <= 1'b0;
            r_hwr     <= 1'b0;
            r_dword   <= '0;
            r_hword   <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (s_valid) mid_frame <= !s_last;
            if (frame_start) begin
                f_active  <= admit;
                f_k_lo    <= cfg_k_lo;
                f_k_hi    <= cfg_k_hi;
                frame_cnt <= frame_cnt + 16'd1;
                if (!win_null && !admit) begin
                    overflow <= 1'b1;
                    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end
            end
            r_dwr <= dwr;
            r_hwr <= hwr;
            if (dwr) r_dword <= {s_k == cur_hi, s_data_3, s_data_2, s_data_1, s_data_0};
            if (hwr) r_hword <= {s_timestamp, frame_cnt, 8'hA5, 4'h0, cfg_lane_mask};
        end
    end

    always_ff @(posedge clk) begin
        if (r_dwr) d_mem[d_wp] <= r_dword;
        if (r_hwr) h_mem[h_wp] <= r_hword;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_wp    <= '0;
            d_rp    <= '0;
            d_count <= '0;
            h_wp    <= '0;
            h_rp    <= '0;
            h_count <= '0;
        end else begin
            if (r_dwr) d_wp <= d_wp + DAW'(1);
            if (d_pop) d_rp <= d_rp + DAW'(1);
            if (r_hwr) h_wp <= h_wp + HAW'(1);
            if (h_pop) h_rp <= h_rp + HAW'(1);
            d_count <= d_count + {{DAW{1'b0}}, r_dwr} - {{DAW{1'b0}}, d_pop};
            h_count <= h_count + {{HAW{1'b0}}, r_hwr} - {{HAW{1'b0}}, h_pop};
        end
    end

    assign d_empty = (d_count == '0);
    assign h_empty = (h_count == '0);
    assign d_head  = d_mem[d_rp];
    assign h_head  = h_mem[h_rp];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            lane   <= 2'd0;
            p_mask <= 4'd0;
        end else begin
            state  <= state_d;
            lane   <= lane_d;
            p_mask <= p_mask_d;
        end
    end

    // Leaving IDLE on a header still in the input register lets tvalid rise
    // two cycles after the frame-start beat.
    always_comb begin
        state_d  = state;
        lane_d   = lane;
        p_mask_d = p_mask;
        h_pop    = 1'b0;
        d_pop    = 1'b0;
        case (state)
            S_IDLE: if (!h_empty || r_hwr) state_d = S_HDR;
            S_HDR: begin
                if (m_axis_tready) begin
                    h_pop    = 1'b1;
                    p_mask_d = h_head[3:0];
                    lane_d   = low_lane(h_head[3:0]);
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (!d_empty && m_axis_tready) begin
                    if (lane == high_lane(p_mask)) begin
                        d_pop  = 1'b1;
                        lane_d = low_lane(p_mask);
                        if (d_head[256]) state_d = S_IDLE;
                    end else begin
                        lane_d = next_lane(p_mask, lane);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A word transfers when tvalid && tready at a rising edge; while tvalid is
    // high without tready, state, pointers and the head entries are frozen, so
    // tdata/tlast hold and tvalid cannot fall until the handshake.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            S_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = h_head;
            end
            S_DATA: begin
                if (!d_empty) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tlast  = d_head[256] && (lane == high_lane(p_mask));
                    case (lane)
                        2'd0:    m_axis_tdata = d_head[63:0];
                        2'd1:    m_axis_tdata = d_head[127:64];
                        2'd2:    m_axis_tdata = d_head[191:128];
                        default: m_axis_tdata = d_head[255:192];
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule
